// File: rtl/div_check_scheduler.sv
// Round-robin front end sharing one MSB-first serial divisibility checker between two requesters.
// Captures the granted word, streams it out serially and reports (value mod DIVISOR) tagged with the owner.
module div_check_scheduler #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVISOR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             divisible,
  output logic [3:0]       residue
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [4:0]  DIV5 = 5'(DIVISOR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [3:0]       r, r_nx;
  logic             cur_id, cur_id_nx;
  logic             ptr, ptr_nx;

  logic             gnt0_nx, gnt1_nx, ser_out_nx, ser_valid_nx, busy_nx, done_nx;
  logic             done_id_nx, divisible_nx;
  logic [3:0]       residue_nx;

  logic [4:0]       sum;
  logic [3:0]       r_upd;
  logic             winner;
  logic [WIDTH-1:0] win_word;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      r         <= '0;
      cur_id    <= 1'b0;
      ptr       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      divisible <= 1'b0;
      residue   <= '0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      r         <= r_nx;
      cur_id    <= cur_id_nx;
      ptr       <= ptr_nx;
      gnt0      <= gnt0_nx;
      gnt1      <= gnt1_nx;
      ser_out   <= ser_out_nx;
      ser_valid <= ser_valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      done_id   <= done_id_nx;
      divisible <= divisible_nx;
      residue   <= residue_nx;
    end
  end

  // Next-state, arbitration and residue update
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    cnt_nx       = cnt;
    r_nx         = r;
    cur_id_nx    = cur_id;
    ptr_nx       = ptr;
    gnt0_nx      = 1'b0;
    gnt1_nx      = 1'b0;
    ser_out_nx   = 1'b0;
    ser_valid_nx = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;
    done_id_nx   = done_id;
    divisible_nx = divisible;
    residue_nx   = residue;

    sum      = {r, 1'b0} + 5'(shreg[WIDTH-1]);
    r_upd    = (sum >= DIV5) ? 4'(sum - DIV5) : sum[3:0];
    winner   = (req0 && req1) ? ptr : req1;
    win_word = winner ? data1 : data0;

    case (state)
      // The DONE cycle hands straight to the next winner so words stream at WIDTH+1 cycles each
      IDLE, DONE: begin
        state_nx = IDLE;
        if (req0 || req1) begin
          state_nx     = SHIFT;
          shreg_nx     = win_word;
          cur_id_nx    = winner;
          r_nx         = '0;
          cnt_nx       = '0;
          ptr_nx       = ~winner;
          gnt0_nx      = ~winner;
          gnt1_nx      = winner;
          busy_nx      = 1'b1;
          ser_valid_nx = 1'b1;
          ser_out_nx   = win_word[WIDTH-1];
        end
      end
      SHIFT: begin
        r_nx     = r_upd;
        shreg_nx = {shreg[WIDTH-2:0], 1'b0};
        cnt_nx   = cnt + CW'(1);
        busy_nx  = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx     = DONE;
          done_nx      = 1'b1;
          done_id_nx   = cur_id;
          residue_nx   = r_upd;
          divisible_nx = (r_upd == 4'd0);
        end else begin
          ser_valid_nx = 1'b1;
          ser_out_nx   = shreg[WIDTH-2];
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_check_scheduler.sv
// Scoreboard bench for div_check_scheduler: a word-level model predicts grants and results,
// a negedge monitor compares serial stream, done pulses and held results.
module tb_div_check_scheduler;

  localparam int W   = 8;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, ser_out, ser_valid, busy, done, done_id, divisible;
  logic [3:0] residue;

  logic       b_req0, b_req1;
  logic [7:0] b_data0, b_data1;
  logic       b_gnt0, b_gnt1, b_ser_out, b_ser_valid, b_busy, b_done, b_done_id, b_divisible;
  logic [3:0] b_residue;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_check_scheduler #(.WIDTH(W), .DIVISOR(DIV)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .done(done), .done_id(done_id), .divisible(divisible), .residue(residue)
  );

  div_check_scheduler #(.WIDTH(8), .DIVISOR(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .data0(b_data0), .req1(b_req1), .data1(b_data1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
    .busy(b_busy), .done(b_done), .done_id(b_done_id), .divisible(b_divisible), .residue(b_residue)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit         id;
    logic [7:0] data;
    int         g;
  } item_t;

  item_t      sb[$];
  int         cyc      = 0;
  bit         pend     = 0;
  bit         pend_id  = 0;
  logic [7:0] pend_data;
  bit         ptr_m    = 0;
  int         free_at  = 0;
  int         last_div = 0;
  int         last_res = 0;
  int         words    = 0;
  int         k;
  int         exp_res;
  bit         w;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("reset_outputs",
          int'({gnt0, gnt1, ser_out, ser_valid, busy, done, done_id, divisible, residue}), 0);
      sb.delete();
      pend = 0; ptr_m = 0; free_at = 0; last_div = 0; last_res = 0;
    end else begin
      chk("grant", int'({gnt1, gnt0}), pend ? (pend_id ? 2 : 1) : 0);
      if (pend) sb.push_back('{pend_id, pend_data, cyc});
      pend = 0;
      if (sb.size() > 0) begin
        k = cyc - sb[0].g;
        chk("busy", int'(busy), 1);
        chk("ser_valid", int'(ser_valid), (k < W) ? 1 : 0);
        chk("done", int'(done), (k == W) ? 1 : 0);
        if (k < W) chk("ser_out", int'(ser_out), int'(sb[0].data[W-1-k]));
        if (k == W) begin
          exp_res = int'(sb[0].data) % DIV;
          chk("done_id", int'(done_id), int'(sb[0].id));
          chk("residue", int'(residue), exp_res);
          chk("divisible", int'(divisible), (exp_res == 0) ? 1 : 0);
          last_res = exp_res;
          last_div = (exp_res == 0) ? 1 : 0;
          words++;
          void'(sb.pop_front());
        end else begin
          chk("residue_hold", int'(residue), last_res);
          chk("divisible_hold", int'(divisible), last_div);
        end
      end else begin
        chk("idle_outputs", int'({busy, ser_valid, done}), 0);
        chk("residue_hold", int'(residue), last_res);
        chk("divisible_hold", int'(divisible), last_div);
      end
      // Predict the capture at the coming edge from the requests now on the pins
      if (cyc >= free_at && (req0 || req1)) begin
        w         = (req0 && req1) ? ptr_m : req1;
        pend      = 1;
        pend_id   = w;
        pend_data = w ? data1 : data0;
        ptr_m     = !w;
        free_at   = cyc + 1 + W;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_gnt(input int id);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step(1);
      if ((id == 0 && gnt0) || (id == 1 && gnt1)) ok = 1;
    end
    if (!ok) chk("gnt_timeout", 0, 1);
  endtask

  task automatic run_b(input logic [7:0] d, input int er);
    bit ok = 0;
    b_req0  = 1'b1;
    b_data0 = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      step(1);
      if (b_gnt0) ok = 1;
    end
    b_req0 = 1'b0;
    if (!ok) chk("div3_gnt_timeout", 0, 1);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (b_done) ok = 1;
    end
    if (!ok) chk("div3_done_timeout", 0, 1);
    else begin
      chk("div3_residue", int'(b_residue), er);
      chk("div3_divisible", int'(b_divisible), (er == 0) ? 1 : 0);
    end
    step(2);
  endtask

  int ng;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h2C; data1 = 8'h2D;
    b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = 8'h00; b_data1 = 8'h00;
    step(2);
    rst = 1'b1;

    // Reset with both requests pending: id0 wins first, id1 follows back-to-back
    wait_gnt(0);
    req0 = 1'b0;
    wait_gnt(1);
    req1 = 1'b0;
    step(12);

    // Both requests held continuously
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h04; data1 = 8'h06;
    ng = 0;
    for (int i = 0; i < 60 && ng < 3; i++) begin
      step(1);
      if (gnt0 || gnt1) ng++;
    end
    if (ng < 3) chk("arb_gnt_timeout", ng, 3);
    req0 = 1'b0; req1 = 1'b0;
    step(12);

    // Randomised requesters obeying the drop-on-grant rule
    for (int i = 0; i < 500; i++) begin
      if (gnt0) begin
        req0 = 1'b0; data0 = 8'($urandom);
      end else if (!req0 && ($urandom % 4 == 0)) begin
        req0 = 1'b1; data0 = 8'($urandom);
      end
      if (gnt1) begin
        req1 = 1'b0; data1 = 8'($urandom);
      end else if (!req1 && ($urandom % 4 == 0)) begin
        req1 = 1'b1; data1 = 8'($urandom);
      end
      step(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(14);

    // Reset in the middle of a requester-0 word while requester 1 waits
    req0 = 1'b1; data0 = 8'($urandom);
    wait_gnt(0);
    req0 = 1'b0; req1 = 1'b1; data1 = 8'h2D;
    step(4);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    wait_gnt(1);
    req1 = 1'b0;
    step(14);

    // DIVISOR = 3 instance
    run_b(8'hFF, 0);
    run_b(8'h64, 1);

    chk("scoreboard_empty", sb.size(), 0);
    chk("words_completed_min", (words >= 20) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
